// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM encodings and default frame/timing constants.
// UART_RX_PARITY_EN adds the PARITY state to the encoding.
package uart_pkg;

  localparam int UART_WIDTH_DEF = 8;
  localparam int UART_CPB_DEF   = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
    ST_PARITY = 3'd3,
`endif
    ST_STOP   = 3'd4
  } rx_state_e;

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-timing down-counter: load sets the interval, expire_o fires on the last cycle of it.
module uart_baud_cnt #(
  parameter  int CLKS_PER_BIT = 2,
  localparam int CW           = $clog2(CLKS_PER_BIT + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_i,
  input  logic [CW-1:0] load_val_i,
  input  logic          en_i,
  output logic          expire_o
);

  logic [CW-1:0] cnt_q, cnt_d;

  // Saturates at 1 so the count never wraps while waiting for a reload.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i)
      cnt_d = load_val_i;
    else if (en_i && (cnt_q > CW'(1)))
      cnt_d = cnt_q - CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign expire_o = en_i && (cnt_q <= CW'(1));

endmodule

// File: rtl/uart_rx.sv
// UART receiver: synchronizer, framing FSM, shift register and one-entry output buffer.
// Define UART_RX_PARITY_EN for an even-parity bit between data and stop bits.
module uart_rx
  import uart_pkg::*;
#(
  parameter int WIDTH        = UART_WIDTH_DEF,
  parameter int CLKS_PER_BIT = UART_CPB_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rx_line,
  output logic [WIDTH-1:0] data,
  output logic             valid,
  input  logic             ready,
  output logic             frame_err,
  output logic             parity_err,
  output logic             overrun
);

  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam int BW = $clog2(WIDTH + 1);

  logic             sync1_q, sync2_q, rx_s;
  rx_state_e        state_q, state_d;
  logic             armed_q, armed_d;
  logic [BW-1:0]    bitcnt_q, bitcnt_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             ferr_q, ferr_d;
  logic             ovr_q, ovr_d;
  logic             bufovr_q, bufovr_d;
  logic             accept, hs;
  logic             baud_load, baud_en, baud_exp;
  logic [CW-1:0]    baud_val;
`ifdef UART_RX_PARITY_EN
  logic             perr_q, perr_d;
`endif

  assign rx_s = sync2_q;

  uart_baud_cnt #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (baud_load),
    .load_val_i (baud_val),
    .en_i       (baud_en),
    .expire_o   (baud_exp)
  );

  assign baud_en = (state_q != ST_IDLE);

  always_comb begin
    state_d   = state_q;
    armed_d   = armed_q;
    bitcnt_d  = bitcnt_q;
    shift_d   = shift_q;
    ferr_d    = 1'b0;
    accept    = 1'b0;
    baud_load = 1'b0;
    baud_val  = CW'(CLKS_PER_BIT);
`ifdef UART_RX_PARITY_EN
    perr_d    = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        // After a framing error, wait for the line to return high before rearming.
        if (!armed_q) begin
          if (rx_s) armed_d = 1'b1;
        end else if (!rx_s) begin
          state_d   = ST_START;
          baud_load = 1'b1;
          baud_val  = CW'(CLKS_PER_BIT / 2);
        end
      end
      ST_START: begin
        if (baud_exp) begin
          if (!rx_s) begin
            state_d   = ST_DATA;
            baud_load = 1'b1;
            bitcnt_d  = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_DATA: begin
        if (baud_exp) begin
          shift_d   = {rx_s, shift_q[WIDTH-1:1]};
          baud_load = 1'b1;
          if (bitcnt_q == BW'(WIDTH - 1)) begin
`ifdef UART_RX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end else begin
            bitcnt_d = bitcnt_q + BW'(1);
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (baud_exp) begin
          if ((^shift_q) ^ rx_s) begin
            perr_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            state_d   = ST_STOP;
            baud_load = 1'b1;
          end
        end
      end
`endif
      ST_STOP: begin
        if (baud_exp) begin
          state_d = ST_IDLE;
          if (rx_s) begin
            accept = 1'b1;
          end else begin
            ferr_d  = 1'b1;
            armed_d = 1'b0;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // bufovr_q marks a buffered byte that survived an overrun; its handshake leaves overrun set.
  assign hs = valid_q && ready;

  always_comb begin
    data_d   = data_q;
    valid_d  = valid_q;
    ovr_d    = ovr_q;
    bufovr_d = bufovr_q;
    if (accept) begin
      if (valid_q && !ready) begin
        ovr_d    = 1'b1;
        bufovr_d = 1'b1;
      end else begin
        data_d   = shift_q;
        valid_d  = 1'b1;
        bufovr_d = 1'b0;
      end
    end else if (hs) begin
      valid_d  = 1'b0;
      bufovr_d = 1'b0;
      if (!bufovr_q) ovr_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      state_q  <= ST_IDLE;
      armed_q  <= 1'b1;
      bitcnt_q <= '0;
      shift_q  <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      ferr_q   <= 1'b0;
      ovr_q    <= 1'b0;
      bufovr_q <= 1'b0;
    end else begin
      sync1_q  <= rx_line;
      sync2_q  <= sync1_q;
      state_q  <= state_d;
      armed_q  <= armed_d;
      bitcnt_q <= bitcnt_d;
      shift_q  <= shift_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      ferr_q   <= ferr_d;
      ovr_q    <= ovr_d;
      bufovr_q <= bufovr_d;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) perr_q <= 1'b0;
    else        perr_q <= perr_d;
  end
  assign parity_err = perr_q;
`else
  assign parity_err = 1'b0;
`endif

  assign data      = data_q;
  assign valid     = valid_q;
  assign frame_err = ferr_q;
  assign overrun   = ovr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx (WIDTH=8, CLKS_PER_BIT=2); parity cases run when UART_RX_PARITY_EN is defined.
module tb_uart_rx;

  localparam int CPB = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx_line;
  logic [7:0] data;
  logic       valid;
  logic       ready;
  logic       frame_err;
  logic       parity_err;
  logic       overrun;

  int n_tests = 0;
  int n_fail  = 0;

  int vcnt = 0;
  int fcnt = 0;
  int pcnt = 0;
  logic [7:0] last_data = 8'h00;

  int v0, f0, p0;

  uart_rx #(.WIDTH(8), .CLKS_PER_BIT(CPB)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_line    (rx_line),
    .data       (data),
    .valid      (valid),
    .ready      (ready),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (valid) begin
      vcnt      <= vcnt + 1;
      last_data <= data;
    end
    if (frame_err)  fcnt <= fcnt + 1;
    if (parity_err) pcnt <= pcnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    rx_line = b;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    rx_line = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input logic par_flip);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    send_bit((^d) ^ par_flip);
`endif
    send_bit(stop);
  endtask

  task automatic snap();
    v0 = vcnt;
    f0 = fcnt;
    p0 = pcnt;
  endtask

  initial begin
    logic [7:0] aa;
    rst_n   = 1'b0;
    rx_line = 1'b1;
    ready   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_data", data, 8'h00);
    chk("rst_valid", valid, 1'b0);
    chk("rst_ferr", frame_err, 1'b0);
    chk("rst_perr", parity_err, 1'b0);
    chk("rst_ovr", overrun, 1'b0);
    rst_n = 1'b1;
    idle(5);

    // single byte with ready held high
    ready = 1'b1;
    snap();
    send_frame(8'h01, 1'b1, 1'b0);
    idle(6);
    chk("b01_vcycles", vcnt - v0, 1);
    chk("b01_data", last_data, 8'h01);
    chk("b01_ferr", fcnt - f0, 0);
    chk("b01_perr", pcnt - p0, 0);
    chk("b01_valid_low", valid, 1'b0);

    // overrun and its clearing
    ready = 1'b0;
    send_frame(8'h05, 1'b1, 1'b0);
    send_frame(8'h07, 1'b1, 1'b0);
    idle(4);
    chk("ovr_valid", valid, 1'b1);
    chk("ovr_data", data, 8'h05);
    chk("ovr_flag", overrun, 1'b1);
    ready = 1'b1;
    @(posedge clk);
    #1;
    chk("ovr_hs_valid", valid, 1'b0);
    send_frame(8'h09, 1'b1, 1'b0);
    idle(6);
    chk("ovr_clear", overrun, 1'b0);
    chk("ovr_next_data", last_data, 8'h09);

    // one-cycle glitch is a false start
    snap();
    rx_line = 1'b0;
    @(posedge clk);
    #1;
    idle(10);
    chk("glitch_valid", vcnt - v0, 0);
    chk("glitch_ferr", fcnt - f0, 0);
    send_frame(8'h5A, 1'b1, 1'b0);
    idle(6);
    chk("glitch_next", last_data, 8'h5A);

    // framing error followed by a held-low break
    snap();
    send_frame(8'h03, 1'b0, 1'b0);
    rx_line = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    chk("brk_ferr_cnt", fcnt - f0, 1);
    chk("brk_valid", vcnt - v0, 0);
    idle(4);
    snap();
    send_frame(8'h03, 1'b1, 1'b0);
    idle(6);
    chk("brk_recover", last_data, 8'h03);
    chk("brk_recover_v", vcnt - v0, 1);

    // reset during data bit 4 of 0xAA
    aa = 8'hAA;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(aa[i]);
    rx_line = aa[4];
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_data", data, 8'h00);
    chk("mid_rst_valid", valid, 1'b0);
    chk("mid_rst_ferr", frame_err, 1'b0);
    chk("mid_rst_perr", parity_err, 1'b0);
    chk("mid_rst_ovr", overrun, 1'b0);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    idle(6);
    send_frame(8'h03, 1'b1, 1'b0);
    idle(6);
    chk("post_rst_data", data, 8'h03);

`ifdef UART_RX_PARITY_EN
    snap();
    send_frame(8'h07, 1'b1, 1'b1);
    idle(6);
    chk("par_bad_perr", pcnt - p0, 1);
    chk("par_bad_valid", vcnt - v0, 0);
    snap();
    send_frame(8'h07, 1'b1, 1'b0);
    idle(6);
    chk("par_good_data", last_data, 8'h07);
    chk("par_good_perr", pcnt - p0, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
